// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
//
// Purpose:
//   Turns symbolic instruction requests (operation, register fields,
//   immediate) into 32-bit MIPS words. Encoded words are queued in a small
//   FIFO and written one per accepted write cycle into instruction memory.
//   Writes start at BASE_ADDR and advance by 4 bytes per word.
//   A syscall request is the last one accepted. Once the syscall word has
//   been written the block raises done and goes idle until reset.
//
// Parameters:
//   BASE_ADDR  byte address of the first written word
//   DEPTH      FIFO entries (power of two, >= 2)
//
// Configuration macro:
//   ENC_RANGE_CHECK_EN  when defined, immediates are range-checked at
//                       acceptance. Violating requests are dropped and set
//                       error.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_op                 operation code (0..12 legal, 13..15 illegal)
//   in_rs/in_rt/in_rd     register fields
//   in_shamt              shift amount for sll
//   in_imm                immediate (16 bits I-type, 26 bits j/jal)
//   wr_en/wr_ready        memory write handshake
//   wr_addr/wr_data       byte address and word of the current write
//   word_count            words written so far (saturating)
//   done                  syscall word has been written
//   error                 sticky: an illegal/out-of-range request was dropped
module mips_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h00003000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [25:0] in_imm,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [15:0] word_count,
  output logic        done,
  output logic        error
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t FULL    = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam ptr_t PTR_ONE = ptr_t'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADDU    = 4'd0;
  localparam logic [3:0] OP_SUBU    = 4'd1;
  localparam logic [3:0] OP_SLL     = 4'd2;
  localparam logic [3:0] OP_JR      = 4'd3;
  localparam logic [3:0] OP_SYSCALL = 4'd4;
  localparam logic [3:0] OP_ADDIU   = 4'd5;
  localparam logic [3:0] OP_ORI     = 4'd6;
  localparam logic [3:0] OP_LW      = 4'd7;
  localparam logic [3:0] OP_SW      = 4'd8;
  localparam logic [3:0] OP_BEQ     = 4'd9;
  localparam logic [3:0] OP_LUI     = 4'd10;
  localparam logic [3:0] OP_JAL     = 4'd11;
  localparam logic [3:0] OP_J       = 4'd12;

  state_t       state;
  logic [31:0]  mem [DEPTH];
  ptr_t         rd_ptr;
  ptr_t         wr_ptr;
  cnt_t         count;

  logic [31:0]  enc_word;
  logic         enc_legal;
  logic         range_ok;
  logic         accept;
  logic         push;
  logic         pop;

  // Encoder: pure function of the request fields. Illegal opcodes clear
  // enc_legal so the request is swallowed without producing a word.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_op)
      OP_ADDU:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
      OP_SUBU:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
      OP_SLL:     enc_word = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, 6'b000000};
      OP_JR:      enc_word = {6'b000000, in_rs, 15'b0, 6'b001000};
      OP_SYSCALL: enc_word = 32'h0000000C;
      OP_ADDIU:   enc_word = {6'b001001, in_rs, in_rt, in_imm[15:0]};
      OP_ORI:     enc_word = {6'b001101, in_rs, in_rt, in_imm[15:0]};
      OP_LW:      enc_word = {6'b100011, in_rs, in_rt, in_imm[15:0]};
      OP_SW:      enc_word = {6'b101011, in_rs, in_rt, in_imm[15:0]};
      OP_BEQ:     enc_word = {6'b000100, in_rs, in_rt, in_imm[15:0]};
      OP_LUI:     enc_word = {6'b001111, 5'b00000, in_rt, in_imm[15:0]};
      OP_JAL:     enc_word = {6'b000011, in_imm};
      OP_J:       enc_word = {6'b000010, in_imm};
      default:    enc_legal = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // Signed immediates must fit in 16 bits as a sign-extended value.
  // Logical immediates (ori/lui) must fit as a zero-extended value.
  always_comb begin
    range_ok = 1'b1;
    case (in_op)
      OP_ADDIU, OP_LW, OP_SW, OP_BEQ: range_ok = (in_imm[25:16] == {10{in_imm[15]}});
      OP_ORI, OP_LUI:                 range_ok = (in_imm[25:16] == 10'b0);
      default:                        range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  // The handshake deliberately ignores a same-cycle pop, so a full FIFO
  // stalls the requester for one cycle even while it is draining.
  assign in_ready = !reset && (state == ST_RUN) && (count < FULL);
  assign wr_en    = !reset && (count != '0) && (state != ST_DONE);
  assign wr_data  = mem[rd_ptr];

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_legal && range_ok;
  assign pop    = wr_en && wr_ready;

  // FIFO storage has no reset. The pointers and count define which entries
  // are meaningful, so stale words are never presented after reset.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  // Control state: pointers, occupancy, write address, counters and the
  // RUN -> DRAIN -> DONE sequence. In DRAIN no pushes occur, so the entry
  // leaving the FIFO when only one remains is the syscall word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wr_addr    <= BASE_ADDR;
      word_count <= 16'h0000;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        wr_addr <= wr_addr + 32'd4;
        if (word_count != 16'hFFFF) begin
          word_count <= word_count + 16'd1;
        end
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (accept && !(enc_legal && range_ok)) begin
        error <= 1'b1;
      end
      case (state)
        ST_RUN: begin
          if (push && (in_op == OP_SYSCALL)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && (count == CNT_ONE)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
//
// Purpose:
//   Self-checking bench for mips_instr_encoder. Requests are issued by a
//   driver, and the expected words are queued in a scoreboard. A monitor
//   compares every memory write against the queue, the running address and
//   the running word count. Expected words come from a reference model that
//   builds each instruction arithmetically from its field values.
//
// Ports: none (top-level bench).
module tb_mips_instr_encoder;

  localparam logic [31:0] BASE  = 32'h00003000;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [25:0] in_imm;
  logic        wr_en;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [15:0] word_count;
  logic        done;
  logic        error;

  mips_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
    .done       (done),
    .error      (error)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cycle    = 0;
  logic [31:0] exp_q[$];
  bit          err_model = 0;
  int          pops = 0;
  bit          done_seen = 0;
  int          sys_pop_cycle = -100;
  bit          prev_stall = 0;
  logic [31:0] prev_data, prev_addr;
  bit          rand_ready = 0;
  bit          force_ready = 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle++;

  // Memory-side ready: either forced or randomly throttled.
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: builds each word from field weights.
  task automatic ref_encode(input int op, input int rs, input int rt, input int rd,
                            input int sh, input int imm,
                            output logic [31:0] w, output bit ok);
    longint v;
    int     s;
    v  = 0;
    ok = 1;
    case (op)
      0:  v = rs * 2**21 + rt * 2**16 + rd * 2**11 + 33;
      1:  v = rs * 2**21 + rt * 2**16 + rd * 2**11 + 35;
      2:  v = rt * 2**16 + rd * 2**11 + sh * 64;
      3:  v = rs * 2**21 + 8;
      4:  v = 12;
      5:  v = longint'(9)  * 2**26 + rs * 2**21 + rt * 2**16 + (imm % 65536);
      6:  v = longint'(13) * 2**26 + rs * 2**21 + rt * 2**16 + (imm % 65536);
      7:  v = longint'(35) * 2**26 + rs * 2**21 + rt * 2**16 + (imm % 65536);
      8:  v = longint'(43) * 2**26 + rs * 2**21 + rt * 2**16 + (imm % 65536);
      9:  v = longint'(4)  * 2**26 + rs * 2**21 + rt * 2**16 + (imm % 65536);
      10: v = longint'(15) * 2**26 + rt * 2**16 + (imm % 65536);
      11: v = longint'(3)  * 2**26 + imm;
      12: v = longint'(2)  * 2**26 + imm;
      default: ok = 0;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    s = (imm >= 2**25) ? imm - 2**26 : imm;
    if (op == 5 || op == 7 || op == 8 || op == 9) begin
      if (s < -32768 || s > 32767) ok = 0;
    end
    if (op == 6 || op == 10) begin
      if (imm >= 65536) ok = 0;
    end
`else
    s = 0;
`endif
    w = 32'(v);
  endtask

  // Offers one request for up to 'budget' cycles. Called and returns at
  // posedge+1. On acceptance the scoreboard and error model are updated at
  // the acceptance edge.
  task automatic apply_stimulus(input int op, input int rs, input int rt, input int rd,
                                input int sh, input int imm,
                                input logic [31:0] exp_word, input bit exp_push,
                                input int budget, output bit acc);
    acc      = 0;
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_shamt = 5'(sh);
    in_imm   = 26'(imm);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      if (acc) begin
        if (exp_push) exp_q.push_back(exp_word);
        else err_model = 1;
      end
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    in_op    = 4'($urandom_range(0, 15));
  endtask

  // Model-driven request; reports a failure if it is not accepted in time.
  task automatic send_model(input int op, input int rs, input int rt, input int rd,
                            input int sh, input int imm, input int budget);
    logic [31:0] w;
    bit ok, acc;
    ref_encode(op, rs, rt, rd, sh, imm, w, ok);
    apply_stimulus(op, rs, rt, rd, sh, imm, w, ok, budget, acc);
    check_output("accept", 32'(acc), 32'd1);
  endtask

  // Random request whose immediate passes any range check.
  task automatic send_safe(input int budget);
    int op;
    op = $urandom_range(0, 12);
    if (op == 4) op = 5;
    send_model(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 32767), budget);
  endtask

  task automatic wait_empty(input int budget);
    bit ok;
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !wr_en) begin
        ok = 1;
        break;
      end
    end
    check_output("drain_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_in_ready", 32'(in_ready), 32'd0);
      check_output("reset_wr_en", 32'(wr_en), 32'd0);
    end
    exp_q.delete();
    err_model     = 0;
    sys_pop_cycle = -100;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_wr_addr", wr_addr, BASE);
    check_output("rst_word_count", 32'(word_count), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_wr_en", 32'(wr_en), 32'd0);
    check_output("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each write against the scoreboard and tracks the
  // running address, word count, sticky error and done timing.
  always @(negedge clk) begin
    if (reset) begin
      pops       = 0;
      prev_stall = 0;
      done_seen  = 0;
    end else begin
      logic [31:0] e;
      check_output("word_count", 32'(word_count), 32'(pops));
      check_output("error", 32'(error), 32'(err_model));
      if (prev_stall && wr_en) begin
        check_output("stall_data", wr_data, prev_data);
        check_output("stall_addr", wr_addr, prev_addr);
      end
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_write", wr_data, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check_output("wr_data", wr_data, e);
          check_output("wr_addr", wr_addr, BASE + 32'(4 * pops));
          if (e == 32'h0000000C) sys_pop_cycle = cycle;
          pops++;
        end
      end
      if (done && !done_seen) begin
        done_seen = 1;
        check_output("done_latency", 32'(cycle), 32'(sys_pop_cycle + 1));
      end
      if (done) begin
        check_output("done_wr_en", 32'(wr_en), 32'd0);
        check_output("done_in_ready", 32'(in_ready), 32'd0);
      end
      prev_stall = wr_en && !wr_ready;
      prev_data  = wr_data;
      prev_addr  = wr_addr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          acc;
    logic [31:0] held;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_op    = 4'd0;
    in_rs    = 5'd0;
    in_rt    = 5'd0;
    in_rd    = 5'd0;
    in_shamt = 5'd0;
    in_imm   = 26'd0;
    do_reset();

    // First write latency and address.
    apply_stimulus(6, 0, 8, 0, 0, 'h1234, 32'h34081234, 1, 5, acc);
    check_output("ori_acc", 32'(acc), 32'd1);
    @(negedge clk);
    check_output("ori_wr_en", 32'(wr_en), 32'd1);
    check_output("ori_addr", wr_addr, BASE);
    check_output("ori_data", wr_data, 32'h34081234);
    @(negedge clk);
    check_output("ori_count", 32'(word_count), 32'd1);
    @(posedge clk);
    #1;

    apply_stimulus(0, 8, 9, 10, 0, 0, 32'h01095021, 1, 5, acc);
    apply_stimulus(2, 0, 9, 10, 4, 0, 32'h00095100, 1, 5, acc);
    apply_stimulus(11, 0, 0, 0, 0, 'hC03, 32'h0C000C03, 1, 5, acc);
    wait_empty(20);

    // Out-of-range addiu immediate.
`ifdef ENC_RANGE_CHECK_EN
    apply_stimulus(5, 0, 8, 0, 0, 'h10000, 32'h0, 0, 5, acc);
    wait_empty(20);
    check_output("addiu_range_err", 32'(error), 32'd1);
`else
    apply_stimulus(5, 0, 8, 0, 0, 'h10000, 32'h24080000, 1, 5, acc);
    wait_empty(20);
    check_output("addiu_range_err", 32'(error), 32'd0);
`endif

    // Backpressure: four fit, the fifth stalls, head word stays stable.
    force_ready = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) send_safe(3);
    apply_stimulus(1, 3, 4, 5, 0, 0, 32'h00642823, 1, 6, acc);
    check_output("fifth_blocked", 32'(acc), 32'd0);
    @(negedge clk);
    check_output("full_in_ready", 32'(in_ready), 32'd0);
    held = wr_data;
    repeat (3) @(negedge clk);
    check_output("full_hold", wr_data, held);
    @(posedge clk);
    #1;
    force_ready = 1;
    apply_stimulus(1, 3, 4, 5, 0, 0, 32'h00642823, 1, 20, acc);
    check_output("fifth_accepted", 32'(acc), 32'd1);
    wait_empty(30);

    // Illegal op is swallowed; a later legal request still goes through.
    apply_stimulus(14, 1, 2, 3, 4, 5, 32'h0, 0, 5, acc);
    check_output("illegal_acc", 32'(acc), 32'd1);
    @(negedge clk);
    check_output("illegal_error", 32'(error), 32'd1);
    check_output("illegal_no_wr", 32'(wr_en), 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(7, 0, 8, 0, 0, 'h0004, 32'h8C080004, 1, 5, acc);
    wait_empty(20);

    // Randomized traffic with throttled memory.
    rand_ready = 1;
    for (int i = 0; i < 80; i++) begin
      int op, imm;
      op = $urandom_range(0, 15);
      if (op == 4) op = 0;
      imm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 32767) : int'($urandom_range(0, 2**26 - 1));
      send_model(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), imm, 40);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready  = 0;
    force_ready = 1;
    wait_empty(60);

    // Reset with a full FIFO: nothing stale may be written afterwards.
    force_ready = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_safe(3);
    force_ready = 1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    apply_stimulus(6, 0, 8, 0, 0, 'h1234, 32'h34081234, 1, 5, acc);
    wait_empty(20);

    // Syscall: stop accepting, write the word, raise done one cycle later.
    send_safe(5);
    apply_stimulus(4, 7, 7, 7, 7, 7, 32'h0000000C, 1, 5, acc);
    check_output("syscall_acc", 32'(acc), 32'd1);
    in_valid = 1'b1;
    in_op    = 4'd0;
    for (int k = 0; k < 20 && !done_seen; k++) begin
      @(negedge clk);
      check_output("drain_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check_output("done_reached", 32'(done_seen), 32'd1);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check_output("final_count", 32'(word_count), 32'(pops));
    check_output("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the stage decoder: accepts symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake and encodes each one into a 32-bit MIPS word.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from BASE_ADDR.
- Used by the bench/bootstrap path to build programs for the pipeline.
- Stops accepting requests after a syscall and reports completion once the syscall word is written.

Parameters:
- BASE_ADDR, 32'h00003000, byte address of the first written word.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request can be accepted this cycle.
- in_op  in  4  0 addu, 1 subu, 2 sll, 3 jr, 4 syscall, 5 addiu, 6 ori, 7 lw, 8 sw, 9 beq, 10 lui, 11 jal, 12 j; 13-15 illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_shamt  in  5  shift amount (sll).
- in_imm  in  26  immediate; low 16 bits for I-type, all 26 bits for j/jal.
- wr_en  out  1  write request to instruction memory.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  32  byte address of the current write.
- wr_data  out  32  encoded instruction word.
- word_count  out  16  number of words written so far.
- done  out  1  syscall word has been written.
- error  out  1  sticky; an illegal or out-of-range request was dropped.

Behaviour:
- Reset, synchronous: state=RUN, FIFO empty, wr_addr=BASE_ADDR, word_count=0, done=0, error=0. wr_en=0 and in_ready=0 while reset is high.
- Acceptance occurs when in_valid && in_ready.
- in_ready = (state==RUN) && (fifo count < DEPTH). It does not look ahead to a same-cycle pop.
- Encoding, standard MIPS:
  - R-type: addu = {000000,rs,rt,rd,00000,100001}; subu = same with funct 100011.
  - sll = {000000,00000,rt,rd,shamt,000000}.
  - jr = {000000,rs,15'b0,001000}; syscall = 32'h0000000C.
  - I-type = {opc,rs,rt,imm[15:0]}, with opc addiu 001001, ori 001101, lw 100011, sw 101011, beq 000100.
  - lui = {001111,00000,rt,imm[15:0]}.
  - J-type: j = {000010,imm[25:0]}; jal = {000011,imm[25:0]}.
  - Fields unused by an op are ignored.
- Encoded word is pushed into the FIFO on the acceptance edge. wr_en rises the next cycle at the earliest, giving 1-cycle latency when the FIFO is empty and wr_ready=1.
- Write side:
  - wr_en = !empty; wr_data = FIFO head.
  - A pop occurs when wr_en && wr_ready. On a pop, wr_addr += 4 and word_count += 1.
  - wr_addr wraps modulo 2^32. word_count saturates at 16'hFFFF.
  - wr_data and wr_addr stay stable while wr_en && !wr_ready.
  - Push and pop may occur in the same cycle; count is unchanged and order is preserved.
- Illegal op (13-15): request is accepted (handshake completes), nothing is pushed, error is set on the next edge. error stays set until reset.
- State machine:
  - RUN: accepting requests. An accepted syscall pushes its word and moves to DRAIN.
  - DRAIN: in_ready=0. The FIFO drains; when the syscall word pops, move to DONE.
  - DONE: done=1 (registered, first high the cycle after the syscall pop), in_ready=0, wr_en=0. Held until reset.
- Reset mid-operation: FIFO contents are discarded; no partial write is completed after the reset edge.

Optional Feature:
- Macro ENC_RANGE_CHECK_EN.
- When defined, requests are range-checked at acceptance:
  - addiu/lw/sw/beq: in_imm[25:16] must all equal in_imm[15].
  - ori/lui: in_imm[25:16] must be 0.
  - A violating request is accepted, not pushed, and sets error.
- When undefined, in_imm[15:0] is used as-is with no check, and error is set only by illegal ops.

Test Plan:
- Reset, then ori rs=0 rt=8 imm=0x1234 with wr_ready=1 -> wr_en next cycle, wr_addr=0x3000, wr_data=0x34081234; word_count becomes 1.
- addu rs=8 rt=9 rd=10, then sll rt=9 rd=10 shamt=4, then jal imm=0x0000C03 -> 0x01095021 @0x3000, 0x00095100 @0x3004, 0x0C000C03 @0x3008.
- Hold wr_ready=0 and offer 5 valid requests back-to-back -> exactly 4 accepted, in_ready=0 afterwards, wr_data stable. Then release wr_ready -> 4 writes in order, then the 5th accepted.
- in_op=14 -> handshake completes, no wr_en, error=1 next cycle. A following lw rs=0 rt=8 imm=0x0004 still writes 0x8C080004.
- syscall -> in_ready=0 from the next cycle, write of 0x0000000C, done=1 one cycle after that pop; later in_valid is ignored.
- addiu rs=0 rt=8 imm=0x10000:
  - with ENC_RANGE_CHECK_EN: no write, error=1.
  - without ENC_RANGE_CHECK_EN: writes 0x24080000, error=0.
